// File: rtl/mac_pkg.sv
// Shared definitions for the fixed-point MAC stage: format defaults, FSM encoding, widths.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mac_pkg;

   // Default word format: 25-bit two's complement with 8 fractional bits, 4 terms per result
   localparam int N_DEF = 25;
   localparam int F_DEF = 8;
   localparam int K_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACUM  = 2'd1,
      SATUR = 2'd2
   } estado_t;

   // Full product width plus enough guard bits that K terms can never wrap
   function automatic int acc_width(input int n, input int k);
      return 2 * n + $clog2(k);
   endfunction

   localparam logic [N_DEF-1:0] SAT_MAX = {1'b0, {(N_DEF-1){1'b1}}};
   localparam logic [N_DEF-1:0] SAT_MIN = {1'b1, {(N_DEF-1){1'b0}}};

endpackage

// File: rtl/saturador_suma.sv
// Combinational clamp of a wide signed accumulator down to an N-bit signed word plus overflow flag.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows input every cycle.
module saturador_suma #(
   parameter int W_IN = 52,
   parameter int N    = 25
) (
   input  logic [W_IN-1:0] acc,
   output logic [N-1:0]    valor,
   output logic            overflow
);

   // The value fits in N bits exactly when every bit from the N-bit sign position upward agrees
   logic [W_IN-N:0] bits_altos;
   assign bits_altos = acc[W_IN-1:N-1];

   // Clamp toward the limit on the side given by the accumulator's true sign bit
   always_comb begin
      valor    = acc[N-1:0];
      overflow = 1'b0;
      if (!((&bits_altos) || !(|bits_altos))) begin
         overflow = 1'b1;
         if (acc[W_IN-1]) begin
            valor = {1'b1, {(N-1){1'b0}}};
         end else begin
            valor = {1'b0, {(N-1){1'b1}}};
         end
      end
   end

endmodule

// File: rtl/acumulador_mac.sv
// Signed fixed-point multiply-accumulate of K (Muestra, Coef) terms, saturated to N bits.
// Latency: result registered one edge after the K-th accepted term; K+2 cycles per result without gaps.
// Backpressure: none; Start ignored while Ocupado, Enable ignored outside ACUM, gaps allowed.
module acumulador_mac
   import mac_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int F = F_DEF,
   parameter int K = K_DEF
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         Start,
   input  logic         Enable,
   input  logic [N-1:0] Muestra,
   input  logic [N-1:0] Coef,
   output logic [N-1:0] ValorSuma,
   output logic         SumaLista,
   output logic         Ocupado,
   output logic         Overflow
);

   localparam int ACC_W = acc_width(N, K);
   localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(K - 1);

   estado_t estado, estado_sig;

   logic signed [2*N-1:0]   muestra_ext, coef_ext, producto;
   logic signed [ACC_W-1:0] acc;
   logic [CNT_W-1:0]        cnt;
   logic                    limpiar, sumar, cargar;
   logic [N-1:0]            valor_sat;
   logic                    ovf_sat;

   // Low 2N bits of the product of sign-extended operands are the exact signed product;
   // the arithmetic shift drops fractional bits, truncating toward minus infinity
   assign muestra_ext = {{N{Muestra[N-1]}}, Muestra};
   assign coef_ext    = {{N{Coef[N-1]}}, Coef};
   assign producto    = (muestra_ext * coef_ext) >>> F;

   saturador_suma #(
      .W_IN (ACC_W),
      .N    (N)
   ) u_saturador (
      .acc      (acc),
      .valor    (valor_sat),
      .overflow (ovf_sat)
   );

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         estado <= IDLE;
      end else begin
         estado <= estado_sig;
      end
   end

   // Next state and datapath controls; Enable in the Start cycle is not a term
   always_comb begin
      estado_sig = estado;
      limpiar    = 1'b0;
      sumar      = 1'b0;
      cargar     = 1'b0;
      Ocupado    = 1'b0;
      case (estado)
         IDLE: begin
            if (Start) begin
               limpiar    = 1'b1;
               estado_sig = ACUM;
            end
         end
         ACUM: begin
            Ocupado = 1'b1;
            if (Enable) begin
               sumar = 1'b1;
               if (cnt == ULTIMO) begin
                  estado_sig = SATUR;
               end
            end
         end
         SATUR: begin
            Ocupado    = 1'b1;
            cargar     = 1'b1;
            estado_sig = IDLE;
         end
         default: begin
            estado_sig = IDLE;
         end
      endcase
   end

   // Accumulator, term counter and result registers; reset discards any partial sum
   always_ff @(posedge CLK) begin
      if (RESET) begin
         acc       <= '0;
         cnt       <= '0;
         ValorSuma <= '0;
         Overflow  <= 1'b0;
         SumaLista <= 1'b0;
      end else begin
         SumaLista <= 1'b0;
         if (limpiar) begin
            acc <= '0;
            cnt <= '0;
         end else if (sumar) begin
            acc <= acc + {{(ACC_W-2*N){producto[2*N-1]}}, producto};
            cnt <= cnt + 1'b1;
         end
         if (cargar) begin
            ValorSuma <= valor_sat;
            Overflow  <= ovf_sat;
            SumaLista <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_acumulador_mac.sv
// Directed bench for acumulador_mac: unity, saturation, truncation, handshake and reset cases.
// Latency: checks result one edge after the 4th term.
// Backpressure: exercises Enable gaps and ignored Start/Enable.
module tb_acumulador_mac;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        Start;
   logic        Enable;
   logic [24:0] Muestra;
   logic [24:0] Coef;
   logic [24:0] ValorSuma;
   logic        SumaLista;
   logic        Ocupado;
   logic        Overflow;

   int n_chk  = 0;
   int n_pass = 0;
   int pulses = 0;

   localparam logic [24:0] UNO     = 25'd256;
   localparam logic [24:0] P23     = 25'h0800000;
   localparam logic [24:0] M23     = 25'h1800000;
   localparam logic [24:0] MENOS1  = 25'h1FFFFFF;

   acumulador_mac dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .Start     (Start),
      .Enable    (Enable),
      .Muestra   (Muestra),
      .Coef      (Coef),
      .ValorSuma (ValorSuma),
      .SumaLista (SumaLista),
      .Ocupado   (Ocupado),
      .Overflow  (Overflow)
   );

   always #5 CLK = ~CLK;

   // Count every SumaLista cycle, sampled mid-cycle
   always @(negedge CLK) begin
      if (SumaLista) pulses++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One full result: Start (with a stray Enable that must not count), 4 terms with gaps,
   // optional Start/Enable pokes during ACUM gaps and SATUR, then pulse/timing checks
   task automatic run_mac(input string tag, input logic [24:0] m, input logic [24:0] c,
                          input int gap, input bit poke);
      int p0;
      p0      = pulses;
      Start   = 1'b1;
      Enable  = 1'b1;
      Muestra = 25'd12345;
      Coef    = 25'd6789;
      tick();
      Start  = 1'b0;
      Enable = 1'b0;
      chk({tag, "_busy"}, 32'(Ocupado), 32'd1);
      for (int i = 0; i < 4; i++) begin
         Enable  = 1'b1;
         Muestra = m;
         Coef    = c;
         tick();
         Enable  = 1'b0;
         Muestra = 25'h0ABCDE;
         Coef    = 25'h0ABCDE;
         if (i < 3) begin
            for (int g = 0; g < gap; g++) begin
               Start = poke;
               tick();
               Start = 1'b0;
            end
         end
      end
      chk({tag, "_early"}, 32'(SumaLista), 32'd0);
      if (poke) begin
         Start   = 1'b1;
         Enable  = 1'b1;
         Muestra = P23;
         Coef    = P23;
      end
      tick();
      Start  = 1'b0;
      Enable = 1'b0;
      chk({tag, "_lista"}, 32'(SumaLista), 32'd1);
      chk({tag, "_idle"}, 32'(Ocupado), 32'd0);
      tick();
      chk({tag, "_onepulse"}, 32'(pulses - p0), 32'd1);
      chk({tag, "_stayidle"}, 32'(Ocupado), 32'd0);
   endtask

   initial begin
      RESET   = 1'b1;
      Start   = 1'b0;
      Enable  = 1'b0;
      Muestra = '0;
      Coef    = '0;
      tick();
      tick();
      RESET = 1'b0;
      chk("rst_valor", 32'(ValorSuma), 32'd0);
      chk("rst_lista", 32'(SumaLista), 32'd0);
      chk("rst_busy", 32'(Ocupado), 32'd0);
      chk("rst_ovf", 32'(Overflow), 32'd0);

      run_mac("unidad", UNO, UNO, 0, 1'b0);
      chk("unidad_valor", 32'(ValorSuma), 32'(25'd1024));
      chk("unidad_ovf", 32'(Overflow), 32'd0);

      run_mac("satpos", P23, P23, 0, 1'b0);
      chk("satpos_valor", 32'(ValorSuma), 32'(25'd16777215));
      chk("satpos_ovf", 32'(Overflow), 32'd1);

      run_mac("satneg", M23, P23, 0, 1'b0);
      chk("satneg_valor", 32'(ValorSuma), 32'(25'h1000000));
      chk("satneg_ovf", 32'(Overflow), 32'd1);

      // Reset after two of four terms: everything clears, partial sum is lost
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         Enable  = 1'b1;
         Muestra = P23;
         Coef    = P23;
         tick();
         Enable = 1'b0;
      end
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      chk("rstmid_valor", 32'(ValorSuma), 32'd0);
      chk("rstmid_ovf", 32'(Overflow), 32'd0);
      chk("rstmid_busy", 32'(Ocupado), 32'd0);
      chk("rstmid_lista", 32'(SumaLista), 32'd0);
      run_mac("fresh", UNO, UNO, 0, 1'b0);
      chk("fresh_valor", 32'(ValorSuma), 32'(25'd1024));
      chk("fresh_ovf", 32'(Overflow), 32'd0);

      run_mac("trunc", MENOS1, 25'd1, 0, 1'b0);
      chk("trunc_valor", 32'(ValorSuma), 32'(25'h1FFFFFC));
      chk("trunc_ovf", 32'(Overflow), 32'd0);

      run_mac("cero", 25'd1, 25'd1, 0, 1'b0);
      chk("cero_valor", 32'(ValorSuma), 32'd0);

      run_mac("hshk", UNO, UNO, 3, 1'b1);
      chk("hshk_valor", 32'(ValorSuma), 32'(25'd1024));
      chk("hshk_ovf", 32'(Overflow), 32'd0);
      repeat (4) tick();
      chk("hshk_hold", 32'(ValorSuma), 32'(25'd1024));
      chk("hshk_quiet", 32'(SumaLista), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
